// File: rtl/alu_issue_pkg.sv
// Shared types for the decode/issue stage: ALU opcodes, RV32I major opcodes
// and the issue record carried through the skid buffer.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LT  = 3'd5,
    ALU_GT  = 3'd6,
    ALU_EQ  = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    alu_op_e         alu_op;
    logic [4:0]      rd;
    logic            wb_en;
    logic            branch;
    logic            invert;
    logic [XLEN-1:0] br_target;
    logic            illegal;
  } issue_t;

  // Shared OP / OP-IMM funct3 mapping; bit 3 of the result flags a legal funct3.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    logic [3:0] r;
    r = '0;
    case (f3)
      3'b000:  r = {1'b1, ALU_ADD};
      3'b111:  r = {1'b1, ALU_AND};
      3'b110:  r = {1'b1, ALU_OR};
      3'b100:  r = {1'b1, ALU_XOR};
      3'b011:  r = {1'b1, ALU_LT};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer: registered in_ready, FIFO order, head held stable
// while the consumer stalls.
module alu_issue_skid #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  T       head_q, head_d;
  T       tail_q, tail_d;
  logic   push, pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_data;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_d = TWO;
            tail_d  = in_data;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = in_data;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: combinational decode/register read, result
// registered into a 2-entry skid buffer toward execute.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [2:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_branch,
  output logic        out_invert,
  output logic [31:0] out_br_target,
  output logic        out_illegal
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, imm_b;
  logic [3:0]  f3_map;
  logic        legal;
  issue_t      dec, out_q;

  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign imm_b    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign f3_map   = f3_to_alu(f3);

  always_comb begin
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.rd        = in_instr[11:7];
    dec.br_target = in_pc + imm_b;
    legal         = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.op1   = rs1_data;
        dec.op2   = rs2_data;
        dec.wb_en = 1'b1;
        if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == 7'b0000000 && f3_map[3]) begin
          dec.alu_op = alu_op_e'(f3_map[2:0]);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.op1    = rs1_data;
        dec.op2    = imm_i;
        dec.wb_en  = 1'b1;
        dec.alu_op = alu_op_e'(f3_map[2:0]);
        legal      = f3_map[3];
      end
      OPC_LUI: begin
        dec.op2   = imm_u;
        dec.wb_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1   = in_pc;
        dec.op2   = imm_u;
        dec.wb_en = 1'b1;
      end
      OPC_BRANCH: begin
        dec.op1    = rs1_data;
        dec.op2    = rs2_data;
        dec.branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001: begin
            dec.alu_op = ALU_EQ;
            dec.invert = 1'b1;
          end
          3'b110:  dec.alu_op = ALU_LT;
          3'b111: begin
            dec.alu_op = ALU_LT;
            dec.invert = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings still flow downstream, but as an inert ADD of zeros.
    if (!legal) begin
      dec.op1     = '0;
      dec.op2     = '0;
      dec.alu_op  = ALU_ADD;
      dec.wb_en   = 1'b0;
      dec.branch  = 1'b0;
      dec.invert  = 1'b0;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wb_en = 1'b0;
  end

  alu_issue_skid #(
    .T(issue_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_q)
  );

  assign out_op1       = out_q.op1;
  assign out_op2       = out_q.op2;
  assign out_alu_op    = out_q.alu_op;
  assign out_rd        = out_q.rd;
  assign out_wb_en     = out_q.wb_en;
  assign out_branch    = out_q.branch;
  assign out_invert    = out_q.invert;
  assign out_br_target = out_q.br_target;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: instructions are built from mnemonics,
// expectations come from the mnemonic semantics, and a queue scoreboard checks order.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [31:0] out_op1, out_op2, out_br_target;
  logic [2:0]  out_alu_op;
  logic        out_wb_en, out_branch, out_invert, out_illegal;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_branch(out_branch),
    .out_invert(out_invert), .out_br_target(out_br_target),
    .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] op1, op2, tgt;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic        wb, br, inv, ill, chk_rd, chk_tgt;
  } exp_t;

  // Mnemonic kinds: 0-5 OP, 6-10 OP-IMM, 11 LUI, 12 AUIPC, 13-16 branches, 17-22 illegal
  localparam int K_ADD = 0, K_ADDI = 6, K_LUI = 11, K_BGEU = 16;
  localparam int K_SRAI = 17, K_SLT = 18, K_LOAD = 19;

  int   n_tests = 0, n_fail = 0;
  exp_t q[$];
  exp_t cur_exp, mon_e;
  bit   rand_rdy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic gen(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input int imm, input logic [31:0] pc,
                     output logic [31:0] ins, output exp_t e);
    logic [31:0] t;
    logic [2:0]  f3r [6];
    logic [2:0]  alur [6];
    logic [2:0]  f3b [4];
    logic [2:0]  alub [4];
    t = imm;
    f3r  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b011};
    alur = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    f3b  = '{3'b000, 3'b001, 3'b110, 3'b111};
    alub = '{3'd7, 3'd7, 3'd5, 3'd5};
    e = '{op1: 0, op2: 0, tgt: 0, alu: 0, rd: rd, wb: 0, br: 0, inv: 0,
          ill: 0, chk_rd: 0, chk_tgt: 0};
    ins = '0;
    if (k <= 5) begin
      ins = {(k == 1) ? 7'b0100000 : 7'b0, rs2, rs1, f3r[k], rd, 7'b0110011};
      e.op1 = rf[rs1]; e.op2 = rf[rs2]; e.alu = alur[k];
      e.wb = (rd != 0); e.chk_rd = 1;
    end else if (k <= 10) begin
      ins = {t[11:0], rs1, (k == 6) ? 3'b000 : f3r[k-5], rd, 7'b0010011};
      e.op1 = rf[rs1]; e.op2 = 32'(imm); e.alu = (k == 6) ? 3'd0 : alur[k-5];
      e.wb = (rd != 0); e.chk_rd = 1;
    end else if (k <= 12) begin
      ins = {t[19:0], rd, (k == 11) ? 7'b0110111 : 7'b0010111};
      e.op1 = (k == 11) ? 32'd0 : pc; e.op2 = 32'(imm) * 32'd4096;
      e.wb = (rd != 0); e.chk_rd = 1;
    end else if (k <= 16) begin
      ins = {t[12], t[10:5], rs2, rs1, f3b[k-13], t[4:1], t[11], 7'b1100011};
      e.op1 = rf[rs1]; e.op2 = rf[rs2]; e.alu = alub[k-13];
      e.br = 1; e.inv = (k == 14 || k == 16); e.tgt = pc + 32'(imm); e.chk_tgt = 1;
    end else begin
      e.ill = 1;
      case (k)
        17: ins = {7'b0100000, t[4:0], rs1, 3'b101, rd, 7'b0010011};
        18: ins = {7'b0, rs2, rs1, 3'b010, rd, 7'b0110011};
        19: ins = {t[11:0], rs1, 3'b010, rd, 7'b0000011};
        20: ins = {t[12], t[10:5], rs2, rs1, 3'b100, t[4:1], t[11], 7'b1100011};
        21: ins = {t[11:0], rs1, 3'b010, rd, 7'b0010011};
        default: ins = {7'b0, t[4:0], rs1, 3'b001, rd, 7'b0010011};
      endcase
    end
  endtask

  function automatic int rand_imm(input int k);
    if (k == 11 || k == 12) return int'($urandom_range(0, 20'hFFFFF));
    if (k >= 13 && k <= 16 || k == 20) return (int'($urandom_range(0, 4095)) - 2048) * 2;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    bit ok;
    ok = 0;
    in_valid = 1; in_instr = ins; in_pc = pc; cur_exp = e;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_kind(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input int imm, input logic [31:0] pc);
    logic [31:0] ins;
    exp_t e;
    gen(k, rd, rs1, rs2, imm, pc, ins, e);
    send(ins, pc, e);
  endtask

  task automatic drain();
    out_ready = 1; rand_rdy = 0;
    for (int c = 0; c < 10 && q.size() != 0; c++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  // Scoreboard: evaluated mid-cycle, when the inputs to the next edge are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() != 0);
      if (out_valid && out_ready && q.size() != 0) begin
        mon_e = q.pop_front();
        check("op1", out_op1, mon_e.op1);
        check("op2", out_op2, mon_e.op2);
        check("alu_op", out_alu_op, mon_e.alu);
        check("wb_en", out_wb_en, mon_e.wb);
        check("branch", out_branch, mon_e.br);
        check("invert", out_invert, mon_e.inv);
        check("illegal", out_illegal, mon_e.ill);
        if (mon_e.chk_rd) check("rd", out_rd, mon_e.rd);
        if (mon_e.chk_tgt) check("br_target", out_br_target, mon_e.tgt);
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  initial begin
    logic [31:0] xi [4];
    exp_t        xe [4];
    int          acc, k;
    logic        rdy3;

    rst_n = 0; in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0; rf[1] = 5; rf[2] = 7; rf[5] = 3; rf[6] = 9;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_op1", out_op1, 0);
    check("rst_op2", out_op2, 0);
    check("rst_tgt", out_br_target, 0);
    tick();

    out_ready = 1;
    send_kind(K_ADD, 5'd3, 5'd1, 5'd2, 0, 32'h100);
    check("lat_valid", out_valid, 1);
    check("add_alu", out_alu_op, 0);
    check("add_op1", out_op1, 5);
    check("add_op2", out_op2, 7);
    check("add_rd", out_rd, 3);
    check("add_wb", out_wb_en, 1);
    send_kind(K_ADDI, 5'd1, 5'd0, 5'd0, -1, 32'h104);
    check("addi_m1_op2", out_op2, 32'hFFFF_FFFF);
    send_kind(K_ADDI, 5'd0, 5'd0, 5'd0, 0, 32'h108);
    check("addi_x0_wb", out_wb_en, 0);
    send_kind(K_BGEU, 5'd0, 5'd5, 5'd6, -16, 32'h1000);
    check("bgeu_alu", out_alu_op, 5);
    check("bgeu_inv", out_invert, 1);
    check("bgeu_br", out_branch, 1);
    check("bgeu_wb", out_wb_en, 0);
    check("bgeu_tgt", out_br_target, 32'h0FF0);

    send_kind(K_ADD, 5'd4, 5'd1, 5'd2, 0, 32'h200);
    send_kind(K_SRAI, 5'd7, 5'd1, 5'd0, 3, 32'h204);
    send_kind(K_SLT, 5'd8, 5'd1, 5'd2, 0, 32'h208);
    send_kind(K_LOAD, 5'd9, 5'd1, 5'd0, 12, 32'h20C);
    send_kind(K_ADD, 5'd10, 5'd2, 5'd1, 0, 32'h210);
    drain();

    // Stall: three offered, two accepted, then full-and-draining cycle.
    for (int i = 0; i < 4; i++) gen(i, 5'(i + 11), 5'd1, 5'd2, 0, 32'h300, xi[i], xe[i]);
    out_ready = 0; acc = 0; rdy3 = 1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_instr = xi[acc]; in_pc = 32'h300; cur_exp = xe[acc];
      @(negedge clk);
      if (c == 2) rdy3 = in_ready;
      if (in_ready) acc++;
      tick();
    end
    check("stall_accepted", acc, 2);
    check("stall_ready3", rdy3, 0);
    out_ready = 1;
    @(negedge clk);
    check("full_drain_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("post_drain_ready", in_ready, 1);
    tick();
    in_valid = 0;
    drain();

    // Asynchronous reset while the buffer is full.
    out_ready = 0;
    send_kind(K_ADD, 5'd3, 5'd1, 5'd2, 0, 32'h400);
    send_kind(K_ADD, 5'd4, 5'd2, 5'd1, 0, 32'h404);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_op1", out_op1, 0);
    check("arst_rd", out_rd, 0);
    check("arst_wb", out_wb_en, 0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("arst_rel_ready", in_ready, 1);
    check("arst_rel_valid", out_valid, 0);
    tick();

    rand_rdy = 1;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0;
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 22));
      if ($urandom_range(0, 3) == 0) tick();
      send_kind(k, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(k),
                $urandom & 32'hFFFF_FFFC);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
